// File: rtl/cache_arb_pkg.sv
// Shared constants for the cache-side request arbiter: default sizing and
// the width of one queued {id, data} entry.
package cache_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 32;
    localparam int DEPTH_DEF   = 8;
    localparam int ID_W_DEF    = $clog2(NUM_REQ_DEF);
    localparam int ENTRY_W_DEF = ID_W_DEF + DATA_W_DEF;

    function automatic int entry_width(input int id_w, input int data_w);
        return id_w + data_w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester after the previous
// winner, and remembers the winner only on an enabled, granted cycle.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx
);

    logic [ID_W-1:0] last_q, last_d;
    logic [ID_W-1:0] cand;
    logic            found;

    // NOTE: every variable gets a default at the top so no path leaves it
    // unassigned (no latch); blocking '=' is used because later lines read
    // the values computed earlier in the same pass.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        cand    = '0;
        found   = 1'b0;
        // Offset NUM_REQ truncates to zero, so the previous winner is searched last.
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = last_q + ID_W'(i);
            if (!found && en && req[cand]) begin
                found        = 1'b1;
                gnt[cand]    = 1'b1;
                gnt_idx      = cand;
            end
        end
        last_d = found ? gnt_idx : last_q;
    end

    // NOTE: state registers use non-blocking '<=' so every flop samples the
    // pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= ID_W'(NUM_REQ - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/req_queue_arbiter.sv
// Shares one circular request queue between NUM_REQ cache ports and drains
// it in order to the memory-side valid/ready port.
module req_queue_arbiter
    import cache_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = $clog2(NUM_REQ_DEF),
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int PNTR_W  = $clog2(DEPTH_DEF),
    parameter int CNT_W   = $clog2(DEPTH_DEF) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      mem_valid,
    output logic [ID_W-1:0]           mem_id,
    output logic [DATA_W-1:0]         mem_data,
    input  logic                      mem_ready,
    output logic [CNT_W-1:0]          occupancy,
    output logic                      full,
    output logic                      empty
);

    localparam int ENTRY_W = entry_width(ID_W, DATA_W);

    logic [PNTR_W-1:0]  head_q, head_d;
    logic [PNTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ENTRY_W-1:0] storage_q [DEPTH];

    logic              pop;
    logic              push;
    logic              grant_en;
    logic [ID_W-1:0]   gnt_idx;
    logic [DATA_W-1:0] wr_data;

    assign occupancy = count_q;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign mem_valid = !empty;
    assign pop       = mem_valid && mem_ready;

    // A full queue may still accept when the head leaves in the same cycle.
    assign grant_en  = !reset && !flush && (!full || pop);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .en      (grant_en),
        .gnt     (req_ready),
        .gnt_idx (gnt_idx)
    );

    assign push = |req_ready;

    always_comb begin
        wr_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                wr_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PNTR_W'(1);
            if (pop)  head_d = head_q + PNTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: the storage array has no reset; occupancy alone decides which
    // entries are meaningful, so resetting it would only cost flops.
    always_ff @(posedge clk) begin
        if (push) begin
            storage_q[tail_q] <= {gnt_idx, wr_data};
        end
    end

    assign {mem_id, mem_data} = storage_q[head_q];

endmodule

// File: tb/tb_req_queue_arbiter.sv
// Self-checking bench: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_req_queue_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 8;
    localparam int PNTR_W  = 3;
    localparam int CNT_W   = 4;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic                      flush = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      mem_valid;
    logic [ID_W-1:0]           mem_id;
    logic [DATA_W-1:0]         mem_data;
    logic                      mem_ready = 1'b0;
    logic [CNT_W-1:0]          occupancy;
    logic                      full;
    logic                      empty;

    int errors = 0;
    int checks = 0;

    req_queue_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .PNTR_W  (PNTR_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .mem_valid (mem_valid),
        .mem_id    (mem_id),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .occupancy (occupancy),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of {id, data} plus the last winner.
    logic [ID_W+DATA_W-1:0] mq[$];
    int m_last = NUM_REQ - 1;

    always @(negedge clk) begin
        bit                 m_full, m_pop, m_en;
        int                 winner, c;
        logic [NUM_REQ-1:0] exp_ready;
        m_full = (mq.size() == DEPTH);
        m_pop  = (mq.size() != 0) && mem_ready;
        m_en   = !reset && !flush && (!m_full || m_pop);
        winner = -1;
        for (int k = 1; k <= NUM_REQ; k++) begin
            c = (m_last + k) % NUM_REQ;
            if (winner < 0 && m_en && req_valid[c]) winner = c;
        end
        exp_ready = '0;
        if (winner >= 0) exp_ready[winner] = 1'b1;

        check("model_req_ready", 64'(req_ready), 64'(exp_ready));
        check("model_occupancy", 64'(occupancy), 64'(mq.size()));
        check("model_empty", 64'(empty), 64'(mq.size() == 0));
        check("model_full", 64'(full), 64'(m_full));
        check("model_mem_valid", 64'(mem_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            check("model_mem_entry", 64'({mem_id, mem_data}), 64'(mq[0]));
        end

        if (reset) begin
            mq.delete();
            m_last = NUM_REQ - 1;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (m_pop) void'(mq.pop_front());
            if (winner >= 0) begin
                mq.push_back({ID_W'(winner), req_data[winner*DATA_W +: DATA_W]});
                m_last = winner;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        req_valid = '0;
        mem_ready = 1'b1;
        n = 0;
        while (!empty && n < 3 * DEPTH) begin
            tick();
            n++;
        end
        check(name, 64'(empty), 64'(1));
    endtask

    initial begin
        // Reset, then idle
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("reset_occupancy", 64'(occupancy), 64'(0));
        check("reset_empty", 64'(empty), 64'(1));
        check("reset_mem_valid", 64'(mem_valid), 64'(0));
        check("reset_req_ready", 64'(req_ready), 64'(0));
        tick();

        // All requesters valid, memory always ready: grants 0,1,2,3,0
        for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = 32'h100 + 32'(i);
        req_valid = 4'b1111;
        mem_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rr_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
            if (k > 0) begin
                check("rr_mem_valid", 64'(mem_valid), 64'(1));
                check("rr_mem_id", 64'(mem_id), 64'((k - 1) % 4));
            end
            tick();
        end
        drain("rr_drain");

        // Requester 2 fills the queue with memory stalled
        mem_ready = 1'b0;
        req_valid = 4'b0100;
        for (int k = 0; k < DEPTH; k++) begin
            req_data[2*DATA_W +: DATA_W] = 32'hA0 + 32'(k);
            #1;
            check("fill_grant", 64'(req_ready), 64'(4'b0100));
            tick();
        end
        req_data[2*DATA_W +: DATA_W] = 32'hA8;
        #1;
        check("fill_full", 64'(full), 64'(1));
        check("fill_occupancy", 64'(occupancy), 64'(8));
        check("fill_ready_blocked", 64'(req_ready), 64'(0));
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_data[2*DATA_W +: DATA_W] = 32'hA8 + 32'(k);
            #1;
            check("full_pushpop_grant", 64'(req_ready), 64'(4'b0100));
            check("full_pushpop_occ", 64'(occupancy), 64'(8));
            check("full_pushpop_data", 64'(mem_data), 64'(32'hA0 + 32'(k)));
            tick();
        end
        drain("full_drain");

        // Single beat latency on an empty queue
        mem_ready = 1'b0;
        req_valid = 4'b0001;
        req_data[0 +: DATA_W] = 32'h11;
        #1;
        check("lat_grant", 64'(req_ready), 64'(4'b0001));
        check("lat_no_fallthrough", 64'(mem_valid), 64'(0));
        tick();
        req_valid = '0;
        mem_ready = 1'b1;
        #1;
        check("lat_mem_valid", 64'(mem_valid), 64'(1));
        check("lat_mem_data", 64'(mem_data), 64'(32'h11));
        check("lat_mem_id", 64'(mem_id), 64'(0));
        tick();
        mem_ready = 1'b0;
        #1;
        check("lat_empty_after_pop", 64'(empty), 64'(1));
        check("lat_mem_valid_low", 64'(mem_valid), 64'(0));

        // Five entries (grants 1,3,1,3,1), then flush; last stays at 1
        req_valid = 4'b1010;
        for (int k = 0; k < 5; k++) tick();
        req_valid = 4'b0001;
        flush = 1'b1;
        #1;
        check("flush_occ_before", 64'(occupancy), 64'(5));
        check("flush_req_ready", 64'(req_ready), 64'(0));
        tick();
        flush = 1'b0;
        req_valid = 4'b1111;
        #1;
        check("flush_occ_after", 64'(occupancy), 64'(0));
        check("flush_last_kept", 64'(req_ready), 64'(4'b0100));
        tick();
        #1;
        check("flush_next_grant", 64'(req_ready), 64'(4'b1000));
        tick();
        drain("flush_drain");

        // Random traffic: pointers wrap several times, model checks order
        for (int k = 0; k < 5 * DEPTH; k++) begin
            req_valid = 4'($urandom_range(0, 15));
            mem_ready = 1'($urandom_range(0, 1));
            for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = $urandom;
            tick();
        end
        drain("random_drain");

        // Reset in mid-operation discards entries and refuses the offer
        mem_ready = 1'b0;
        req_valid = 4'b1111;
        for (int k = 0; k < 3; k++) tick();
        reset = 1'b1;
        #1;
        check("midreset_req_ready", 64'(req_ready), 64'(0));
        tick();
        reset = 1'b0;
        #1;
        check("midreset_occupancy", 64'(occupancy), 64'(0));
        check("midreset_priority", 64'(req_ready), 64'(4'b0001));
        tick();
        drain("final_drain");
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
